// File: rtl/box_pkg.sv
// Shared screen geometry and coordinate helpers for the box demo and the VGA timing stage.
package box_pkg;

  localparam int ACTIVE_WIDTH  = 640;
  localparam int ACTIVE_HEIGHT = 480;
  localparam int COORD_W       = 10;

  localparam logic [COORD_W-1:0] RESET_X = 10'd220;
  localparam logic [COORD_W-1:0] RESET_Y = 10'd140;

  // Moves pos one step toward inc/dec (none when both or neither) and clamps to [0, max_pos].
  // One extra bit keeps an underflow below zero visible as a negative value.
  function automatic logic [COORD_W-1:0] step_clamp(
    input logic [COORD_W-1:0] pos,
    input logic               dec,
    input logic               inc,
    input logic [COORD_W:0]   step,
    input logic [COORD_W:0]   max_pos
  );
    logic signed [COORD_W:0] sum;
    sum = $signed({1'b0, pos});
    if (dec && !inc) begin
      sum = sum - $signed(step);
    end else if (inc && !dec) begin
      sum = sum + $signed(step);
    end
    if (sum[COORD_W]) begin
      sum = '0;
    end else if (sum > $signed(max_pos)) begin
      sum = $signed(max_pos);
    end
    return sum[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stability counter; the output level flips only
// after the synchronised input has disagreed with it for DEBOUNCE_COUNT straight cycles.
module btn_debounce #(
  parameter int DEBOUNCE_COUNT = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic level_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_COUNT + 1);

  logic [1:0]       sync_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any cycle where the input agrees with the accepted level restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_COUNT - 1)) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/box_mover.sv
// Moves a square box once per frame according to debounced direction buttons,
// clamping it inside the active area.
module box_mover
  import box_pkg::*;
#(
  parameter int STEP           = 4,
  parameter int DEBOUNCE_COUNT = 250000,
  parameter int BOX_SIZE       = 200
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               v_sync,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_left,
  input  logic               btn_right,
  output logic [COORD_W-1:0] box_x,
  output logic [COORD_W-1:0] box_y,
  output logic               moved
);

  localparam logic [COORD_W:0] STEP_W = (COORD_W + 1)'(STEP);
  localparam logic [COORD_W:0] MAX_X  = (COORD_W + 1)'(ACTIVE_WIDTH - BOX_SIZE);
  localparam logic [COORD_W:0] MAX_Y  = (COORD_W + 1)'(ACTIVE_HEIGHT - BOX_SIZE);

  // Bit order: 3 up, 2 down, 1 left, 0 right.
  logic [3:0] btn_raw;
  logic [3:0] btn_db;

  assign btn_raw = {btn_up, btn_down, btn_left, btn_right};

  for (genvar gi = 0; gi < 4; gi++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_COUNT(DEBOUNCE_COUNT)
    ) u_db (
      .clk    (clk),
      .reset  (reset),
      .btn_i  (btn_raw[gi]),
      .level_o(btn_db[gi])
    );
  end

  logic               vs_q, vs_q2;
  logic               frame_tick;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic               moved_q, moved_d;

  assign frame_tick = vs_q2 & ~vs_q;

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    moved_d = 1'b0;
    if (frame_tick) begin
      x_d     = step_clamp(x_q, btn_db[1], btn_db[0], STEP_W, MAX_X);
      y_d     = step_clamp(y_q, btn_db[3], btn_db[2], STEP_W, MAX_Y);
      moved_d = (x_d != x_q) || (y_d != y_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_q    <= 1'b0;
      vs_q2   <= 1'b0;
      x_q     <= RESET_X;
      y_q     <= RESET_Y;
      moved_q <= 1'b0;
    end else begin
      vs_q    <= v_sync;
      vs_q2   <= vs_q;
      x_q     <= x_d;
      y_q     <= y_d;
      moved_q <= moved_d;
    end
  end

  assign box_x = x_q;
  assign box_y = y_q;
  assign moved = moved_q;

endmodule
